// File: rtl/dsm_pkg.sv
// Shared delta-sigma constants and helpers used by the DAC and the CIC decimator.
package dsm_pkg;

  localparam int unsigned DSM_OSR     = 6;
  localparam int unsigned DSM_DOUT_BW = 16;

  // Internal CIC width for a 3rd-order filter with decimation 2^osr.
  function automatic int unsigned CIC_W(input int unsigned osr);
    return 3 * osr + 2;
  endfunction

  // Clamp a signed value into the two's-complement range of bw bits.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int unsigned      bw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bw - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/dsm_cic_decimator_integ.sv
// Enabled modulo-2^W accumulator; sum_c exposes the post-update value for chaining.
module cic_integ_stage
  import dsm_pkg::*;
#(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] sum_c
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  assign sum_c = acc_q + add_i;

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = sum_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dsm_cic_decimator.sv
// Sinc3 CIC decimator: 1-bit delta-sigma stream in, scaled and saturated PCM out.
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int unsigned OSR     = DSM_OSR,
  parameter int unsigned DOUT_BW = DSM_DOUT_BW,
  parameter int unsigned SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               din,
  output logic [DOUT_BW-1:0] dout,
  output logic               dout_valid,
  output logic               sat,
  output logic               settled
);

  localparam int unsigned W     = CIC_W(OSR);
  localparam int unsigned SHIFT = 3 * OSR + 1 - DOUT_BW;
  localparam int unsigned SCW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  logic [W-1:0] x;
  logic [W-1:0] i1_sum;
  logic [W-1:0] i2_sum;
  logic [W-1:0] i3_sum;

  assign x = din ? W'(1) : {W{1'b1}};

  // Unpipelined integrator chain: each stage adds the previous stage's new value.
  cic_integ_stage #(.W(W)) u_integ1 (
    .clk(clk), .rst_n(rst_n), .en(en), .add_i(x),      .sum_c(i1_sum));
  cic_integ_stage #(.W(W)) u_integ2 (
    .clk(clk), .rst_n(rst_n), .en(en), .add_i(i1_sum), .sum_c(i2_sum));
  cic_integ_stage #(.W(W)) u_integ3 (
    .clk(clk), .rst_n(rst_n), .en(en), .add_i(i2_sum), .sum_c(i3_sum));

  logic [OSR-1:0]     cnt_q, cnt_d;
  logic               decim_q, decim_d;
  logic [W-1:0]       icap_q, icap_d;
  logic [W-1:0]       d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [DOUT_BW-1:0] dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               sat_q, sat_d;
  logic               settled_q, settled_d;

  logic signed [W-1:0] c1, c2, c3;
  logic signed [W-1:0] s_v;
  logic signed [31:0]  sat_v;
  logic                clipped;

  always_comb begin
    cnt_d        = cnt_q;
    decim_d      = 1'b0;
    icap_d       = icap_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    d3_d         = d3_q;
    settle_cnt_d = settle_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sat_d        = 1'b0;
    settled_d    = settled_q;

    c1      = icap_q - d1_q;
    c2      = c1 - d2_q;
    c3      = c2 - d3_q;
    s_v     = c3 >>> SHIFT;
    sat_v   = saturate(32'(s_v), DOUT_BW);
    clipped = (sat_v != 32'(s_v));

    if (en) begin
      cnt_d = cnt_q + OSR'(1);
      if (&cnt_q) begin
        decim_d = 1'b1;
        icap_d  = i3_sum;
      end
    end

    // Settling frames still advance the comb delays; only the output is held back.
    if (decim_q) begin
      d1_d = icap_q;
      d2_d = c1;
      d3_d = c2;
      if (settle_cnt_q < SCW'(SETTLE)) begin
        settle_cnt_d = settle_cnt_q + SCW'(1);
      end else begin
        dout_d       = sat_v[DOUT_BW-1:0];
        dout_valid_d = 1'b1;
        sat_d        = clipped;
        settled_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      decim_q      <= 1'b0;
      icap_q       <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      settle_cnt_q <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      settled_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      decim_q      <= decim_d;
      icap_q       <= icap_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      d3_q         <= d3_d;
      settle_cnt_q <= settle_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sat_q        <= sat_d;
      settled_q    <= settled_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat        = sat_q;
  assign settled    = settled_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed self-checking bench for dsm_cic_decimator (OSR=6, DOUT_BW=16, SETTLE=2).
module tb_dsm_cic_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        din;
  logic [15:0] dout;
  logic        dout_valid;
  logic        sat;
  logic        settled;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_en_cyc = 0;
  int nv;
  logic [15:0] cap_dout = '0;
  logic        cap_sat = 1'b0;
  logic        cap_settled = 1'b0;

  dsm_cic_decimator #(.OSR(6), .DOUT_BW(16), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dout(dout), .dout_valid(dout_valid), .sat(sat), .settled(settled));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid === 1'b1) begin
      n_valid        <= n_valid + 1;
      prev_valid_cyc <= valid_cyc;
      valid_cyc      <= cyc;
      cap_dout       <= dout;
      cap_sat        <= sat;
      cap_settled    <= settled;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic pat(input int kind, input int i);
    case (kind)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 2) == 0;
      default: return (i % 4) != 3;
    endcase
  endfunction

  task automatic drive_bits(input int n, input int kind, input int gap);
    for (int i = 0; i < n; i++) begin
      din = pat(kind, i);
      en  = 1'b1;
      last_en_cyc = cyc;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic flush();
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",    $signed(dout), 0);
    check("rst_valid",   dout_valid, 0);
    check("rst_sat",     sat, 0);
    check("rst_settled", settled, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Constant ones: two frames suppressed, frame 3 emits full scale clipped.
    drive_bits(191, 0, 0);
    check("s1_no_early_pulse", n_valid, 0);
    check("s1_not_settled", settled, 0);
    drive_bits(1, 0, 0);
    check("s1_latency_edge1", dout_valid, 0);
    @(posedge clk); #1;
    check("s1_valid",   dout_valid, 1);
    check("s1_dout",    $signed(dout), 32767);
    check("s1_sat",     sat, 1);
    check("s1_settled", settled, 1);
    check("s1_latency", cyc - last_en_cyc, 2);
    @(posedge clk); #1;
    check("s1_pulse_width", dout_valid, 0);
    check("s1_hold",        $signed(dout), 32767);
    check("s1_sat_clear",   sat, 0);
    nv = n_valid;
    drive_bits(64, 0, 0);
    flush();
    check("s1_next_count", n_valid, nv + 1);
    check("s1_next_dout",  $signed(cap_dout), 32767);
    check("s1_next_sat",   cap_sat, 1);

    // Constant zeros: exact negative full scale.
    drive_bits(192, 1, 0);
    flush();
    check("s2_dout",    $signed(cap_dout), -32768);
    check("s2_sat",     cap_sat, 0);
    check("s2_settled", cap_settled, 1);

    // Alternating 1,0: zero mean.
    drive_bits(192, 2, 0);
    flush();
    check("s3_dout", $signed(cap_dout), 0);
    check("s3_sat",  cap_sat, 0);

    // Repeating 1,1,1,0: mean 0.5.
    drive_bits(192, 3, 0);
    flush();
    check("s4_dout", $signed(cap_dout), 16384);
    check("s4_sat",  cap_sat, 0);

    // Same pattern with en every third cycle.
    drive_bits(192, 3, 2);
    check("s5_dout",    $signed(cap_dout), 16384);
    check("s5_latency", valid_cyc - last_en_cyc, 2);
    nv = n_valid;
    drive_bits(64, 3, 2);
    check("s5_count",   n_valid, nv + 1);
    check("s5_dout2",   $signed(cap_dout), 16384);
    check("s5_sat",     cap_sat, 0);
    check("s5_spacing", valid_cyc - prev_valid_cyc, 192);
    check("s5_latency2", valid_cyc - last_en_cyc, 2);

    // Mid-frame reset pulse during constant ones.
    drive_bits(222, 0, 0);
    check("s6_pre_dout", $signed(dout), 32767);
    rst_n = 1'b0;
    #1;
    check("s6_async_dout",    $signed(dout), 0);
    check("s6_async_settled", settled, 0);
    check("s6_async_valid",   dout_valid, 0);
    check("s6_async_sat",     sat, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nv = n_valid;
    drive_bits(191, 0, 0);
    check("s6_no_early_pulse", n_valid, nv);
    check("s6_not_settled",    settled, 0);
    drive_bits(1, 0, 0);
    flush();
    check("s6_count",   n_valid, nv + 1);
    check("s6_dout",    $signed(cap_dout), 32767);
    check("s6_sat",     cap_sat, 1);
    check("s6_settled", cap_settled, 1);
    check("s6_latency", valid_cyc - last_en_cyc, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsm_cic_decimator.md
Name: dsm_cic_decimator

Overview:
- Receive-side counterpart to the team's 2nd-order delta-sigma DAC. Consumes a 1-bit delta-sigma bitstream, for example from an external comparator-based modulator or a DAC loopback, and reconstructs multi-bit PCM samples.
- Filter is a 3rd-order CIC (sinc3) with decimation ratio R = 2^OSR, followed by scaling, saturation and a valid strobe.
- Sits between the 1-bit input pin (already synchronised) and the Lorenz datapath / capture logic.

Parameters:
- OSR, 6, log2 of the decimation ratio (R = 64).
- DOUT_BW, 16, output sample width, signed two's complement. Constraint: 3*OSR+1 >= DOUT_BW.
- SETTLE, 2, number of initial decimated outputs suppressed after reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  bit-rate enable; din is sampled only on cycles with en=1.
- din  input  1  delta-sigma bit; 1 -> +1, 0 -> -1.
- dout  output  DOUT_BW  decimated signed sample.
- dout_valid  output  1  one-cycle pulse; dout is valid when high.
- sat  output  1  high alongside dout_valid when the current sample was clipped.
- settled  output  1  high once SETTLE outputs have been discarded; stays high until reset.

Behaviour:
- Internal width W = 3*OSR+2, signed (20 bits at the defaults).
- Integrators and combs use modulo-2^W arithmetic. Wrap-around is intentional and must not be saturated.

Reset (asynchronous, rst_n=0):
- All integrators, comb delays, decimation counter and settle counter go to 0.
- Outputs: dout=0, dout_valid=0, sat=0, settled=0.
- Deasserting reset mid-stream restarts the filter cleanly. The first SETTLE outputs after release are suppressed again.

Integrator section (updates only when en=1):
- x = +1 or -1 from din.
- I1 <= I1+x; I2 <= I2+I1_new; I3 <= I3+I2_new.
- Implementation may register between stages, provided the sample-aligned result matches the unpipelined sum chain.

Decimation counter:
- cnt counts en cycles 0..R-1 and wraps.
- On the en cycle where cnt==R-1, a decimate strobe is registered and I3 (post-update) is captured.
- en=0 cycles freeze everything except output pulse clearing.

Comb section:
- Runs once per decimate strobe, in the cycle after it.
- C1 = I3cap - D1; C2 = C1 - D2; C3 = C2 - D3.
- Delay registers update: D1<=I3cap, D2<=C1, D3<=C2.

Output stage (registered, cycle after the comb):
- y = C3 is in the range [-2^(3*OSR), +2^(3*OSR)].
- s = y >>> (3*OSR+1-DOUT_BW), arithmetic shift.
- Clamp to [-2^(DOUT_BW-1), 2^(DOUT_BW-1)-1]; sat=1 if clamped.

Latency and strobes:
- dout_valid pulses exactly 2 clk cycles after the en cycle that delivered the R-th bit of a frame.
- dout_valid is independent of en on those cycles: it fires even if en=0.
- dout holds its value between pulses.
- The first SETTLE frames after reset are processed, updating the comb delays, but dout_valid stays low for them.
- settled rises together with the first emitted dout_valid.

Throughput and edge cases:
- Minimum en spacing is 1 cycle, i.e. en held high continuously is legal.
- The comb/output path never overlaps itself because R >= 2.

Decomposition:
- Shared package dsm_pkg holds:
  - default OSR / DOUT_BW constants shared with the DAC;
  - a CIC_W(osr) function returning 3*osr+2;
  - a saturate-to-width function.
- One natural sub-module: cic_integ_stage, a W-bit enabled accumulator instantiated three times. Combs and output logic stay in the top.

Test Plan:
- Constant din=1, en=1: after reset, the first dout_valid is at frame 3 (cycle 3*64+1 after the first en). Response is dout=32767, sat=1 on every pulse thereafter.
- Constant din=0: dout=-32768, sat=0, exact with no clipping.
- Alternating 1,0 pattern: dout=0 on every valid pulse.
- Repeating 1,1,1,0 pattern: mean 0.5, so y=2^17. Response is dout=16384, sat=0.
- en high every 3rd cycle with pattern 1,1,1,0: same sample values as the previous scenario, with dout_valid spacing of 192 clk. Each pulse lands 2 clk after the frame's 64th en.
- rst_n pulsed low for 1 cycle mid-frame during din=1: outputs clear asynchronously and settled=0. After release, the first dout_valid reappears only after 3 full frames, with value 32767.
